cpu_fetch_ctrl: RTL and testbench
=================================

# cpu_fetch_ctrl

Fetch sequencer between the instruction memory port and the instruction FIFO (`cpu_ififo`). It owns the fetch PC and issues one 32-bit word read at a time. Returned words are pushed into the FIFO, and fetching stalls while the FIFO is full or while the core requests a halt. On a branch/exception redirect it flushes the FIFO, discards any in-flight read, and restarts from the new target. A missing memory acknowledge is reported as a sticky fault.

## Interface
Parameters:
- `BOOT_ADDRESS`, 32'h00001000, PC value loaded on reset
- `ACK_TIMEOUT`, 255, maximum cycles a request may wait for `imem_ack_i` (legal 2..255)

Ports:
- `clk_i`  in  1  single clock; all state changes on its rising edge
- `rst_i`  in  1  synchronous, active-high reset
- `halt_i`  in  1  when 1, no new request is issued; an outstanding request still completes
- `redirect_i`  in  1  one-cycle pulse: restart fetch at `redirect_pc_i`
- `redirect_pc_i`  in  32  redirect target; bits [1:0] ignored (forced to 00)
- `imem_req_o`  out  1  read request, held until acknowledged
- `imem_addr_o`  out  32  word address of the request, low 2 bits always 00
- `imem_ack_i`  in  1  read complete; `imem_data_i` valid in the same cycle
- `imem_data_i`  in  32  fetched word, big-endian (lowest byte address in [31:24])
- `fifo_full_i`  in  1  FIFO full flag
- `fifo_wr_en_o`  out  1  one-cycle FIFO write strobe
- `fifo_data_o`  out  32  word to the FIFO, valid while `fifo_wr_en_o`=1
- `fifo_flush_o`  out  1  one-cycle FIFO clear pulse
- `pc_o`  out  32  address of the next word to fetch (the internal PC)
- `fault_o`  out  1  sticky: acknowledge timeout occurred

## Operation
- All outputs are registered.
- Reset values:
  - state = IDLE
  - PC = `BOOT_ADDRESS`
  - `imem_req_o`, `fifo_wr_en_o`, `fifo_flush_o`, `fault_o` = 0
  - `imem_addr_o`, `fifo_data_o` = 0
  - wait counter = 0
- States: IDLE, REQ, WR, DISCARD, FAULT.
- IDLE:
  - If `halt_i`=0 and `fifo_full_i`=0: set `imem_req_o`=1, `imem_addr_o`=PC, clear the counter, go to REQ.
  - Otherwise stay in IDLE.
- REQ: `imem_req_o` and `imem_addr_o` stay stable; the counter increments each cycle.
  - On `imem_ack_i`=1: `imem_req_o`=0, `fifo_data_o`=`imem_data_i`, `fifo_wr_en_o`=1, PC=PC+4 (mod 2^32), go to WR.
- WR: `fifo_wr_en_o`=0, go to IDLE. This extra cycle lets `fifo_full_i` reflect the write before IDLE samples it, so the FIFO is never written while full.
- DISCARD: `imem_req_o` stays 1 until `imem_ack_i`; on ack, `imem_req_o`=0, data dropped, go to IDLE.
- Timeout (REQ or DISCARD): if the counter reaches `ACK_TIMEOUT`-1 with no ack, set `imem_req_o`=0, `fault_o`=1, go to FAULT.
- FAULT: stays there until `rst_i`; all inputs except `rst_i` are ignored.
- Redirect (`redirect_i`=1) in any state except FAULT; it has priority over every other transition in the same cycle:
  - PC = {`redirect_pc_i`[31:2], 2'b00}
  - `fifo_flush_o`=1 for exactly one cycle; `fifo_wr_en_o`=0
  - From REQ without ack: go to DISCARD (request held; its data will be dropped).
  - From REQ with ack in the same cycle: data dropped, `imem_req_o`=0, go to IDLE.
  - From DISCARD without ack: stay in DISCARD.
  - From DISCARD with ack: `imem_req_o`=0, go to IDLE.
  - From IDLE or WR: go to IDLE. A write strobe already asserted in WR completes before the flush takes effect.
- `halt_i` and `fifo_full_i` are sampled only in IDLE.
- `rst_i` mid-transaction returns to reset values on the next edge; a late ack arriving after reset is ignored in IDLE.

## Timing
- Request issue: `imem_req_o` rises 1 cycle after the IDLE cycle in which the issue conditions hold.
- Ack at the earliest: in the first cycle `imem_req_o`=1.
- Write: `fifo_wr_en_o` is high in the cycle after the ack, for 1 cycle.
- Best-case throughput: 1 word per 3 cycles (IDLE, REQ, WR).
- Redirect-to-new-request latency: 2 cycles from `redirect_i` when no read is outstanding.
- `fifo_flush_o` and the PC update are visible 1 cycle after `redirect_i`.
- Fault: `fault_o` rises `ACK_TIMEOUT` cycles after `imem_req_o` rises, with `imem_req_o` falling on the same edge.

## Test plan
- Reset, then a zero-wait memory returning 32'hDEADBEEF at 0x1000 and 32'h01234567 at 0x1004 → requests at 0x1000, 0x1004, 0x1008…; FIFO writes carry those words; one write per 3 cycles.
- `fifo_full_i`=1 held for 10 cycles after the first write → no new `imem_req_o` during that time; the request to 0x1004 issues 1 cycle after full drops.
- Memory with 4-cycle ack latency, `redirect_i` with target 32'h00002006 in the second wait cycle → `fifo_flush_o` pulses once; the stale word is not written; the next request goes to 0x2004.
- `redirect_i` in the same cycle as `imem_ack_i` → no `fifo_wr_en_o`; `pc_o`=redirect target; the next request is at the target.
- Memory never acks, `ACK_TIMEOUT`=8 → `fault_o`=1 and `imem_req_o`=0 exactly 8 cycles after the request rises; a later redirect is ignored; `rst_i` clears the fault and PC=0x1000.
- `rst_i` asserted while in REQ → next cycle: all outputs at reset values; fetch restarts at `BOOT_ADDRESS`.

Source files
------------

// File: rtl/cpu_fetch_ctrl.sv
// Instruction fetch sequencer: issues one word read at a time, pushes returned words into the
// instruction FIFO, and handles redirects, halts and acknowledge timeouts.
module cpu_fetch_ctrl #(
  parameter logic [31:0] BOOT_ADDRESS = 32'h0000_1000,
  parameter int unsigned ACK_TIMEOUT  = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        halt_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_data_i,
  input  logic        fifo_full_i,
  output logic        fifo_wr_en_o,
  output logic [31:0] fifo_data_o,
  output logic        fifo_flush_o,
  output logic [31:0] pc_o,
  output logic        fault_o
);

  typedef enum logic [2:0] {StIdle, StReq, StWr, StDiscard, StFault} state_e;

  localparam logic [31:0] BootPc      = {BOOT_ADDRESS[31:2], 2'b00};
  localparam logic [7:0]  TimeoutLast = 8'(ACK_TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        req_q, req_d;
  logic [31:0] addr_q, addr_d;
  logic        wr_q, wr_d;
  logic [31:0] data_q, data_d;
  logic        flush_q, flush_d;
  logic        fault_q, fault_d;
  logic [7:0]  cnt_q, cnt_d;

  logic        timeout;
  logic [7:0]  cnt_inc;

  // '>=' so a timeout still fires if redirects kept the request in DISCARD past the limit
  assign timeout = (cnt_q >= TimeoutLast);
  assign cnt_inc = (cnt_q == 8'hff) ? cnt_q : cnt_q + 8'd1;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    req_d   = req_q;
    addr_d  = addr_q;
    wr_d    = 1'b0;
    data_d  = data_q;
    flush_d = 1'b0;
    fault_d = fault_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      StIdle: begin
        if (!halt_i && !fifo_full_i) begin
          req_d   = 1'b1;
          addr_d  = pc_q;
          cnt_d   = 8'd0;
          state_d = StReq;
        end
      end
      StReq: begin
        cnt_d = cnt_inc;
        if (imem_ack_i) begin
          req_d   = 1'b0;
          data_d  = imem_data_i;
          wr_d    = 1'b1;
          pc_d    = pc_q + 32'd4;
          state_d = StWr;
        end else if (timeout) begin
          req_d   = 1'b0;
          fault_d = 1'b1;
          state_d = StFault;
        end
      end
      StWr: begin
        state_d = StIdle;
      end
      StDiscard: begin
        cnt_d = cnt_inc;
        if (imem_ack_i) begin
          req_d   = 1'b0;
          state_d = StIdle;
        end else if (timeout) begin
          req_d   = 1'b0;
          fault_d = 1'b1;
          state_d = StFault;
        end
      end
      StFault: begin
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Redirect overrides whatever the state decode chose this cycle.
    if (redirect_i && (state_q != StFault)) begin
      pc_d    = {redirect_pc_i[31:2], 2'b00};
      flush_d = 1'b1;
      wr_d    = 1'b0;
      data_d  = data_q;
      fault_d = fault_q;
      case (state_q)
        StReq, StDiscard: begin
          if (imem_ack_i) begin
            req_d   = 1'b0;
            state_d = StIdle;
          end else begin
            req_d   = 1'b1;
            state_d = StDiscard;
          end
        end
        default: begin
          req_d   = req_q;
          addr_d  = addr_q;
          cnt_d   = cnt_q;
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      pc_q    <= BootPc;
      req_q   <= 1'b0;
      addr_q  <= 32'd0;
      wr_q    <= 1'b0;
      data_q  <= 32'd0;
      flush_q <= 1'b0;
      fault_q <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      data_q  <= data_d;
      flush_q <= flush_d;
      fault_q <= fault_d;
      cnt_q   <= cnt_d;
    end
  end

  assign imem_req_o   = req_q;
  assign imem_addr_o  = addr_q;
  assign fifo_wr_en_o = wr_q;
  assign fifo_data_o  = data_q;
  assign fifo_flush_o = flush_q;
  assign pc_o         = pc_q;
  assign fault_o      = fault_q;

endmodule

// File: tb/tb_cpu_fetch_ctrl.sv
// Bench for cpu_fetch_ctrl: a transaction-level memory/redirect model feeds a scoreboard of
// expected FIFO writes, PC, flush and fault values; directed scenarios then a random phase.
module tb_cpu_fetch_ctrl;

  localparam logic [31:0] Boot = 32'h0000_1000;
  localparam int          Tmo  = 8;

  logic        clk_i, rst_i, halt_i, redirect_i, imem_req_o, imem_ack_i, fifo_full_i;
  logic        fifo_wr_en_o, fifo_flush_o, fault_o;
  logic [31:0] redirect_pc_i, imem_addr_o, imem_data_i, fifo_data_o, pc_o;

  cpu_fetch_ctrl #(
    .BOOT_ADDRESS(Boot),
    .ACK_TIMEOUT (Tmo)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .halt_i       (halt_i),
    .redirect_i   (redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_ack_i   (imem_ack_i),
    .imem_data_i  (imem_data_i),
    .fifo_full_i  (fifo_full_i),
    .fifo_wr_en_o (fifo_wr_en_o),
    .fifo_data_o  (fifo_data_o),
    .fifo_flush_o (fifo_flush_o),
    .pc_o         (pc_o),
    .fault_o      (fault_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // Reference model state, owned by the driver.
  logic [31:0] exp_pc = Boot;
  logic [31:0] exp_data_q[$];
  bit          redir_last  = 1'b0;
  bit          fault_model = 1'b0;
  bit          outstanding = 1'b0;
  bit          squashed    = 1'b0;
  int          wait_cnt    = 0;
  int          lat         = 0;
  logic [31:0] req_addr    = 32'd0;

  // Stimulus knobs, set by the sequencer.
  int          lat_min = 0, lat_max = 0, p_red = 0, p_halt = 0, p_full = 0;
  bit          no_ack = 1'b0, spurious = 1'b0, full_hold = 1'b0, force_redir = 1'b0;
  logic [31:0] force_target = 32'd0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_1000) return 32'hDEAD_BEEF;
    if (a == 32'h0000_1004) return 32'h0123_4567;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory responder and transaction model; acts on the falling edge.
  initial begin : driver
    bit          red, ack, ack_real;
    logic [31:0] target;
    halt_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'd0;
    imem_ack_i = 1'b0; imem_data_i = 32'd0; fifo_full_i = 1'b0;
    forever begin
      @(negedge clk_i);
      red = 1'b0; ack = 1'b0; ack_real = 1'b0; target = $urandom;
      if (rst_i) begin
        exp_pc = Boot; exp_data_q.delete(); outstanding = 1'b0; fault_model = 1'b0;
        force_redir = 1'b0;
      end else begin
        if (!outstanding && imem_req_o && !fault_model) begin
          outstanding = 1'b1; squashed = 1'b0; wait_cnt = 0; req_addr = imem_addr_o;
          lat = int'($urandom_range(lat_max, lat_min));
        end
        red = force_redir || (p_red > 0 && int'($urandom_range(99, 0)) < p_red);
        if (force_redir) target = force_target;
        force_redir = 1'b0;
        if (outstanding) ack = !no_ack && (wait_cnt >= lat);
        else ack = spurious && ($urandom_range(5, 0) == 0);
        ack_real = ack && outstanding;
        if (fault_model) begin
          red = red;
        end else begin
          if (red) begin
            exp_pc = {target[31:2], 2'b00};
            if (outstanding) squashed = 1'b1;
          end
          if (outstanding) begin
            if (ack) begin
              if (!squashed) begin
                exp_data_q.push_back(mem_word(req_addr));
                exp_pc = exp_pc + 32'd4;
              end
              outstanding = 1'b0;
            end else if (!red && wait_cnt >= Tmo - 1) begin
              fault_model = 1'b1;
              outstanding = 1'b0;
            end
            wait_cnt++;
          end
        end
      end
      redir_last    = red && !fault_model && !rst_i;
      redirect_i    = red;
      redirect_pc_i = target;
      imem_ack_i    = ack;
      imem_data_i   = ack_real ? mem_word(req_addr) : $urandom;
      halt_i        = p_halt > 0 && int'($urandom_range(99, 0)) < p_halt;
      fifo_full_i   = full_hold || (p_full > 0 && int'($urandom_range(99, 0)) < p_full);
    end
  end

  // Monitor: compares DUT outputs against the model just after each rising edge.
  initial begin : monitor
    bit req_prev = 1'b0;
    forever begin
      @(posedge clk_i); #1;
      check("pc", pc_o, exp_pc);
      check("flush", 32'(fifo_flush_o), 32'(redir_last));
      check("fault", 32'(fault_o), 32'(fault_model));
      if (fifo_wr_en_o) begin
        if (exp_data_q.size() == 0) check("unexpected_write", fifo_data_o, 32'hxxxx_xxxx);
        else check("wr_data", fifo_data_o, exp_data_q.pop_front());
      end
      if (imem_req_o && !req_prev) check("req_addr", imem_addr_o, exp_pc);
      req_prev = imem_req_o;
    end
  end

  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    repeat (2) tick();
    rst_i = 1'b0;
  endtask

  // Waits for a fresh rising edge of imem_req_o (low first, then high).
  task automatic wait_req(input string name);
    int n = 0;
    while (imem_req_o && n < 60) begin tick(); n++; end
    while (!imem_req_o && n < 60) begin tick(); n++; end
    if (!imem_req_o) check({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_wr(input string name);
    int n = 0;
    while (!fifo_wr_en_o && n < 60) begin tick(); n++; end
    if (!fifo_wr_en_o) check({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_req"}, 32'(imem_req_o), 32'd0);
    check({tag, "_addr"}, imem_addr_o, 32'd0);
    check({tag, "_wr"}, 32'(fifo_wr_en_o), 32'd0);
    check({tag, "_data"}, fifo_data_o, 32'd0);
    check({tag, "_flush"}, 32'(fifo_flush_o), 32'd0);
    check({tag, "_fault"}, 32'(fault_o), 32'd0);
    check({tag, "_pc"}, pc_o, Boot);
  endtask

  initial begin : sequencer
    int n;
    bit stalled;
    rst_i = 1'b1;
    repeat (3) tick();
    check_reset_values("reset");
    rst_i = 1'b0;

    // Zero-wait streaming
    wait_req("first_req");
    check("first_addr", imem_addr_o, 32'h0000_1000);
    wait_wr("first_wr");
    check("first_word", fifo_data_o, 32'hDEAD_BEEF);
    wait_req("second_req");
    check("second_addr", imem_addr_o, 32'h0000_1004);
    wait_wr("second_wr");
    check("second_word", fifo_data_o, 32'h0123_4567);
    repeat (4) tick();
    n = 0;
    repeat (30) begin tick(); if (fifo_wr_en_o) n++; end
    check("throughput_30cyc", 32'(n), 32'd10);

    // FIFO full stalls issue
    do_reset();
    wait_wr("full_wr");
    full_hold = 1'b1;
    stalled = 1'b0;
    repeat (10) begin tick(); if (imem_req_o) stalled = 1'b1; end
    check("full_no_req", 32'(stalled), 32'd0);
    full_hold = 1'b0;
    tick();
    check("full_release_req", 32'(imem_req_o), 32'd1);
    check("full_release_addr", imem_addr_o, 32'h0000_1004);

    // Redirect during the second wait cycle of a 4-cycle read
    do_reset();
    lat_min = 4; lat_max = 4;
    wait_req("redir_req");
    tick();
    force_target = 32'h0000_2006; force_redir = 1'b1;
    tick();
    check("redir_flush", 32'(fifo_flush_o), 32'd1);
    check("redir_pc", pc_o, 32'h0000_2004);
    wait_req("redir_next_req");
    check("redir_next_addr", imem_addr_o, 32'h0000_2004);

    // Redirect in the same cycle as the acknowledge
    do_reset();
    lat_min = 0; lat_max = 0;
    wait_req("rack_req");
    force_target = 32'h0000_300B; force_redir = 1'b1;
    tick();
    check("rack_no_wr", 32'(fifo_wr_en_o), 32'd0);
    check("rack_pc", pc_o, 32'h0000_3008);
    wait_req("rack_next_req");
    check("rack_next_addr", imem_addr_o, 32'h0000_3008);

    // Acknowledge timeout
    do_reset();
    no_ack = 1'b1;
    wait_req("tmo_req");
    n = 0;
    while (!fault_o && n < 20) begin tick(); n++; end
    check("tmo_cycles", 32'(n), 32'(Tmo));
    check("tmo_req_low", 32'(imem_req_o), 32'd0);
    p_red = 100;
    repeat (4) tick();
    p_red = 0;
    check("fault_pc_held", pc_o, 32'h0000_1000);
    check("fault_sticky", 32'(fault_o), 32'd1);
    no_ack = 1'b0;
    do_reset();
    check("fault_cleared", 32'(fault_o), 32'd0);
    check("fault_reset_pc", pc_o, Boot);

    // Reset in the middle of a request
    lat_min = 3; lat_max = 3;
    wait_req("mid_req");
    rst_i = 1'b1;
    tick();
    check_reset_values("midrst");
    rst_i = 1'b0;
    wait_req("midrst_next_req");
    check("midrst_next_addr", imem_addr_o, Boot);

    // Random traffic
    lat_min = 0; lat_max = 5; p_red = 8; p_halt = 20; p_full = 20; spurious = 1'b1;
    repeat (3000) tick();
    p_red = 0; p_halt = 0; p_full = 0; spurious = 1'b0;
    repeat (20) tick();
    check("drain_empty", 32'(exp_data_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
